cdc_handshake_rx: RTL
=====================

Name: cdc_handshake_rx

Overview:
Destination-side receiver for the four-phase req/ack CDC transfer.
- The source domain loads a K-bit holding register, then raises req_in.
- This block synchronises req_in and captures the quasi-static data bus.
- It presents the captured word to the local consumer with a valid/ready handshake.
- It returns ack_out to the source.
- Sits entirely in the destination clock domain, between the source holding register and the local consumer.

Parameters:
K, 8, data word width in bits
SYNC_STAGES, 2, flops in the req_in synchroniser chain; legal values 2 and above

Ports:
clk  input  1  destination-domain clock, rising edge
rst  input  1  synchronous, active-high reset
req_in  input  1  asynchronous request level from the source domain
data_in  input  K  source holding-register output; stable while req_in is high
ack_out  output  1  acknowledge level back to the source domain
data_out  output  K  captured word
valid_out  output  1  data_out holds an unconsumed word
ready_in  input  1  consumer can accept data_out this cycle
err_out  output  1  sticky protocol-violation flag

Behaviour:
Reset:
- rst is sampled on the rising clk edge. Synchronous, active-high.
- Effect: all sync flops = 0, state = IDLE, data_out = 0, valid_out = 0, ack_out = 0, err_out = 0.

Synchroniser:
- Chain s[0..SYNC_STAGES-1]; s[0] <= req_in; req_s = s[SYNC_STAGES-1].
- No other logic reads req_in directly.
- data_in is sampled only in the capture cycle; it is never synchronised.

State machine: IDLE, HOLD, ACK.
- IDLE: if req_s = 1, then at the next edge data_out <= data_in, valid_out <= 1, go to HOLD. Otherwise stay.
- HOLD: valid_out = 1. If ready_in = 1, then at the next edge valid_out <= 0, ack_out <= 1, go to ACK. If req_s = 0 in HOLD, set err_out (sticky); the transfer still completes normally.
- ACK: ack_out = 1. If req_s = 0, then at the next edge ack_out <= 0, go to IDLE. Otherwise stay in ACK.

Latency:
- req_in rising before edge 1 gives req_s = 1 after edge SYNC_STAGES and valid_out = 1 after edge SYNC_STAGES+1.
- Consumer accept at edge n gives ack_out = 1 after edge n.
- ack_out falls SYNC_STAGES+1 edges after req_in falls.

Boundary conditions:
- ready_in while valid_out = 0: ignored.
- Same-cycle valid_out & ready_in: accepted at that edge, with no bubble requirement on the consumer side.
- data_out holds the last captured word after consume, until the next capture. It is never cleared except by rst.
- Back-to-back transfers: a new capture requires the full sequence IDLE → req_s = 1. Overrun is impossible by protocol.
- req_in glitch shorter than one clk period: may or may not be captured. If captured and already low in HOLD, err_out is set.
- rst mid-transfer: immediate return to IDLE with ack_out = 0 and the sync chain cleared. If req_in is still high after rst, it is treated as a new request; a fresh capture follows after SYNC_STAGES+1 edges.
- err_out clears only on rst.

Test Plan:
1. Reset, K=8, SYNC_STAGES=2: drive data_in = 8'hA5, raise req_in before edge 1 -> valid_out = 1 and data_out = 8'hA5 after edge 3; ack_out = 0 until accept.
2. Hold ready_in = 0 for 5 cycles, then 1 for one cycle -> valid_out stays 1 with data_out = 8'hA5 throughout; after the accept edge valid_out = 0 and ack_out = 1. Drop req_in -> ack_out = 0 three edges later, state IDLE, data_out still 8'hA5.
3. Back-to-back: words 8'h01, 8'h02, 8'h03 with a source model that raises req after ack falls, ready_in tied 1 -> consumer receives exactly 01, 02, 03 in order, no duplicates, err_out = 0.
4. Change data_in to 8'hFF after capture while still in HOLD -> data_out remains the captured value.
5. Protocol violation: raise req_in, then drop it while in HOLD before ready_in -> err_out = 1 and stays 1; transfer completes on accept, state returns to IDLE.
6. Assert rst for one cycle while in ACK with req_in still high -> at that edge ack_out = 0, valid_out = 0, err_out = 0, data_out = 0; a new capture with valid_out = 1 follows three edges after rst deasserts.

Source files
------------

// File: rtl/cdc_handshake_rx.sv
// Destination-side receiver of a four-phase req/ack CDC transfer: synchronises
// req_in, captures the quasi-static data bus and hands it out on valid/ready.
module cdc_handshake_rx #(
    parameter int K           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_in,
    input  logic [K-1:0] data_in,
    output logic         ack_out,
    output logic [K-1:0] data_out,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   req_s;
    state_t                 state;
    state_t                 state_next;
    logic                   capture;
    logic                   valid_next;
    logic                   ack_next;
    logic                   err_next;

    // req_in is the only signal crossing here; data_in is trusted to be stable
    // whenever the synchronised request is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_chain[SYNC_STAGES-1];

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        valid_next = valid_out;
        ack_next   = ack_out;
        err_next   = err_out;
        case (state)
            IDLE: begin
                if (req_s) begin
                    capture    = 1'b1;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // The source dropping req before ack is a protocol violation,
                // flagged but otherwise tolerated so the consumer still drains.
                if (!req_s) begin
                    err_next = 1'b1;
                end
                if (ready_in) begin
                    valid_next = 1'b0;
                    ack_next   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                ack_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_out  <= '0;
            valid_out <= 1'b0;
            ack_out   <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            state     <= state_next;
            valid_out <= valid_next;
            ack_out   <= ack_next;
            err_out   <= err_next;
            if (capture) begin
                data_out <= data_in;
            end
        end
    end

endmodule
